// File: rtl/scan_clk_gen.sv
// Programmable refresh timebase: square led_clk, one-cycle tick on every toggle, digit scan with active-low anodes.
// All outputs registered; reloads of the half-period are staged and take effect only at a terminal edge (or at once while paused).
module scan_clk_gen #(
    parameter int DIV_W    = 24,
    parameter int DEF_HALF = 104166,
    parameter int DIGITS   = 8,
    parameter int IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             half_load,
    input  logic [DIV_W-1:0] half_in,
    output logic             led_clk,
    output logic             tick,
    output logic             half_busy,
    output logic [IDX_W-1:0] digit_idx,
    output logic [DIGITS-1:0] anode
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  half_act_q, half_act_d;
    logic [DIV_W-1:0]  half_shadow_q, half_shadow_d;
    logic              half_busy_q, half_busy_d;
    logic              led_q, led_d;
    logic              tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic              term;

    // half_act is never zero, so half_act-1 cannot wrap
    assign term = en && (cnt_q == (half_act_q - DIV_W'(1)));

    always_comb begin
        cnt_d         = cnt_q;
        half_act_d    = half_act_q;
        half_shadow_d = half_shadow_q;
        half_busy_d   = half_busy_q;
        led_d         = led_q;
        tick_d        = 1'b0;
        idx_d         = idx_q;
        anode_d       = anode_q;

        if (en) begin
            if (term) begin
                cnt_d  = '0;
                led_d  = ~led_q;
                tick_d = 1'b1;
                if (!led_q) begin
                    idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                    anode_d = ~(DIGITS'(1) << idx_d);
                end
                if (half_busy_q) begin
                    half_act_d  = half_shadow_q;
                    half_busy_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else if (half_busy_q) begin
            // Paused: nothing is mid-period, so the new value can take over immediately
            half_act_d  = half_shadow_q;
            half_busy_d = 1'b0;
            cnt_d       = '0;
        end

        // A fresh load always re-arms the shadow, even on the edge that consumes the old one
        if (half_load) begin
            half_shadow_d = (half_in == '0) ? DIV_W'(1) : half_in;
            half_busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q         <= '0;
            half_act_q    <= DIV_W'(DEF_HALF);
            half_shadow_q <= '0;
            half_busy_q   <= 1'b0;
            led_q         <= 1'b0;
            tick_q        <= 1'b0;
            idx_q         <= '0;
            anode_q       <= ~(DIGITS'(1));
        end else begin
            cnt_q         <= cnt_d;
            half_act_q    <= half_act_d;
            half_shadow_q <= half_shadow_d;
            half_busy_q   <= half_busy_d;
            led_q         <= led_d;
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            anode_q       <= anode_d;
        end
    end

    assign led_clk   = led_q;
    assign tick      = tick_q;
    assign half_busy = half_busy_q;
    assign digit_idx = idx_q;
    assign anode     = anode_q;

endmodule

// File: tb/tb_scan_clk_gen.sv
// Bench for scan_clk_gen with a small configuration: directed scenarios plus randomized traffic against a toggle-count model.
module tb_scan_clk_gen;
    localparam int DIV_W    = 8;
    localparam int DEF_HALF = 4;
    localparam int DIGITS   = 4;
    localparam int IDX_W    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             half_load;
    logic [DIV_W-1:0] half_in;
    logic             led_clk;
    logic             tick;
    logic             half_busy;
    logic [IDX_W-1:0] digit_idx;
    logic [DIGITS-1:0] anode;

    scan_clk_gen #(.DIV_W(DIV_W), .DEF_HALF(DEF_HALF), .DIGITS(DIGITS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .en(en), .half_load(half_load), .half_in(half_in),
        .led_clk(led_clk), .tick(tick), .half_busy(half_busy),
        .digit_idx(digit_idx), .anode(anode)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: led_clk and digit follow from the total number of toggles since reset
    int m_pos, m_half, m_shadow, m_tog;
    bit m_pend, m_tick;

    logic [8:0] obs;
    assign obs = {led_clk, tick, half_busy, digit_idx, anode};

    function automatic logic [8:0] exp_vec();
        int d;
        logic [3:0] one;
        logic [3:0] an;
        d   = ((m_tog + 1) / 2) % DIGITS;
        one = 4'b0001;
        an  = ~(one << d);
        return {1'(m_tog % 2), m_tick, m_pend, 2'(d), an};
    endfunction

    task automatic step();
        bit pend0;
        int shad0;
        @(posedge clk);
        if (!rst) begin
            m_pos = 0; m_half = DEF_HALF; m_shadow = 0; m_pend = 0; m_tog = 0; m_tick = 0;
        end else begin
            pend0 = m_pend;
            shad0 = m_shadow;
            m_tick = 0;
            if (en) begin
                if (m_pos + 1 == m_half) begin
                    m_tog++; m_tick = 1; m_pos = 0;
                    if (pend0) begin m_half = shad0; m_pend = 0; end
                end else begin
                    m_pos++;
                end
            end else if (pend0) begin
                m_half = shad0; m_pend = 0; m_pos = 0;
            end
            if (half_load) begin
                m_shadow = (half_in == 0) ? 1 : int'(half_in);
                m_pend = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; half_load = 1'b0; half_in = '0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; half_load = 1'b1; half_in = 8'd9;
        step(); step();
        n_tests++;
        if (obs !== 9'b000_00_1110) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", obs, 9'b000_00_1110);
        end
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %b expected %b", obs, exp_vec());
        end
        half_load = 1'b0;
    endtask

    task automatic test_first_toggle();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL first_toggle edge %0d: got %b expected %b", i, obs, exp_vec());
            end
            if (i % 4 == 0) begin
                n_tests++;
                if (tick !== 1'b1 || led_clk !== 1'((i / 4) % 2)) begin
                    n_fail++; $display("FAIL toggle_edge %0d: tick=%b led=%b expected tick=1 led=%0d", i, tick, led_clk, (i / 4) % 2);
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] one;
        int d;
        one = 4'b0001;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            d = ((i + 4) / 8) % 4;
            n_tests++;
            if (digit_idx !== 2'(d) || anode !== ~(one << d)) begin
                n_fail++; $display("FAIL scan edge %0d: idx=%0d anode=%b expected idx=%0d anode=%b", i, digit_idx, anode, d, ~(one << d));
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1;
        step();
        half_load = 1'b1; half_in = 8'd2;
        step();
        half_load = 1'b0;
        n_tests++;
        if (half_busy !== 1'b1) begin
            n_fail++; $display("FAIL load_busy_set: got %b expected 1", half_busy);
        end
        step();
        step();
        n_tests++;
        if (tick !== 1'b1 || led_clk !== 1'b1 || half_busy !== 1'b0) begin
            n_fail++; $display("FAIL load_apply: tick=%b led=%b busy=%b expected 1 1 0", tick, led_clk, half_busy);
        end
        for (int i = 5; i <= 12; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec() || tick !== 1'(i % 2 == 0)) begin
                n_fail++; $display("FAIL load_run edge %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        en = 1'b1;
        half_load = 1'b1; half_in = 8'd0;
        step();
        half_load = 1'b0;
        for (int i = 2; i <= 12; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec() || (i >= 4 && tick !== 1'b1)) begin
                n_fail++; $display("FAIL clamp edge %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_freeze();
        logic [8:0] snap;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        snap = obs;
        snap[7] = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (obs !== snap) begin
                n_fail++; $display("FAIL freeze cycle %0d: got %b expected %b", i, obs, snap);
            end
        end
        en = 1'b1;
        step();
        n_tests++;
        if (tick !== 1'b0 || led_clk !== 1'b1) begin
            n_fail++; $display("FAIL resume_1: tick=%b led=%b expected 0 1", tick, led_clk);
        end
        step();
        n_tests++;
        if (tick !== 1'b1 || led_clk !== 1'b0) begin
            n_fail++; $display("FAIL resume_2: tick=%b led=%b expected 1 0", tick, led_clk);
        end
        half_load = 1'b1; half_in = 8'd3;
        step();
        half_load = 1'b0;
        rst = 1'b0;
        step();
        n_tests++;
        if (obs !== 9'b000_00_1110) begin
            n_fail++; $display("FAIL mid_reset: got %b expected %b", obs, 9'b000_00_1110);
        end
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL post_reset edge %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        half_load = 1'b1; half_in = 8'd2;
        step();
        half_load = 1'b0;
        step(); step();
        half_load = 1'b1; half_in = 8'd6;
        step();
        half_load = 1'b0;
        n_tests++;
        if (tick !== 1'b1 || half_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_term: tick=%b busy=%b expected 1 1", tick, half_busy);
        end
        step();
        n_tests++;
        if (tick !== 1'b0 || half_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_between: tick=%b busy=%b expected 0 1", tick, half_busy);
        end
        step();
        n_tests++;
        if (tick !== 1'b1 || half_busy !== 1'b0 || led_clk !== 1'b0) begin
            n_fail++; $display("FAIL b2b_apply: tick=%b busy=%b led=%b expected 1 0 0", tick, half_busy, led_clk);
        end
        for (int i = 7; i <= 18; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec() || tick !== 1'(i == 12 || i == 18)) begin
                n_fail++; $display("FAIL b2b_run edge %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 9) < 8);
            half_load = ($urandom_range(0, 19) == 0);
            half_in   = 8'($urandom_range(0, 5));
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random cycle %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        half_load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; half_load = 1'b0; half_in = '0;
        m_pos = 0; m_half = DEF_HALF; m_shadow = 0; m_pend = 0; m_tog = 0; m_tick = 0;
        test_reset();
        test_first_toggle();
        test_scan();
        test_load();
        test_clamp();
        test_freeze();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
